// File: rtl/bnn_seq_if.sv
// Handshake and datapath-control bundle between the BNN frame sequencer and its surroundings.
// The master side is the sequencer. The slave side is the upstream feature source together with the datapath.
interface bnn_seq_if;
   logic       start;
   logic       abort;
   logic       mfcc_valid;
   logic       mfcc_ready;
   logic [5:0] dp_count;
   logic       acc_clr;
   logic       acc_en;
   logic       cmp_en;
   logic [1:0] result_in;
   logic [1:0] result_out;
   logic       result_valid;
   logic       vad_duration;
   logic       busy;

   modport master (
      input  start, abort, mfcc_valid, result_in,
      output mfcc_ready, dp_count, acc_clr, acc_en, cmp_en,
             result_out, result_valid, vad_duration, busy
   );

   modport slave (
      output start, abort, mfcc_valid, result_in,
      input  mfcc_ready, dp_count, acc_clr, acc_en, cmp_en,
             result_out, result_valid, vad_duration, busy
   );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Frame sequencer for the binary VAD classifier: streams NUM_POS MFCC columns into the accumulator,
// strobes the compare, and then latches the class. It also tracks a speech hangover run.
module bnn_seq_ctrl #(
   parameter int NUM_POS     = 36,
   parameter int HANG_FRAMES = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   bnn_seq_if.master    bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ACCUM   = 2'b01,
      ST_COMPARE = 2'b10,
      ST_RESULT  = 2'b11
   } state_e;

   localparam logic [5:0] LAST_POS_C = 6'(NUM_POS - 1);
   localparam logic [7:0] HANG_C     = 8'(HANG_FRAMES);
   localparam logic [1:0] SPEECH_C   = 2'b10;

   state_e     state_q, state_d;
   logic [5:0] dp_count_q, dp_count_d;
   logic [1:0] result_out_q, result_out_d;
   logic [7:0] run_cnt_q, run_cnt_d;
   logic       vad_q, vad_d;
   logic       busy_q, busy_d;
   logic       ready_s;
   logic       beat_s;

   // An abort also withdraws ready, so the beat that arrives with the abort is never accepted.
   assign ready_s = (state_q == ST_ACCUM) && !bus.abort;
   assign beat_s  = ready_s && bus.mfcc_valid;

   assign bus.mfcc_ready   = ready_s;
   assign bus.acc_en       = beat_s;
   assign bus.acc_clr      = beat_s && (dp_count_q == 6'd0);
   assign bus.cmp_en       = (state_q == ST_COMPARE) && !bus.abort;
   assign bus.result_valid = (state_q == ST_RESULT) && !bus.abort;
   assign bus.dp_count     = dp_count_q;
   assign bus.result_out   = result_out_q;
   assign bus.vad_duration = vad_q;
   assign bus.busy         = busy_q;

   // Next-state, column index, result and hangover-run computation.
   always_comb begin
      state_d      = state_q;
      dp_count_d   = dp_count_q;
      result_out_d = result_out_q;
      run_cnt_d    = run_cnt_q;
      if (bus.abort) begin
         state_d    = ST_IDLE;
         dp_count_d = 6'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_ACCUM;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACCUM: begin
               if (beat_s && (dp_count_q == LAST_POS_C)) begin
                  dp_count_d = 6'd0;
                  state_d    = ST_COMPARE;
               end else if (beat_s) begin
                  dp_count_d = dp_count_q + 6'd1;
               end else begin
                  dp_count_d = dp_count_q;
               end
            end
            ST_COMPARE: begin
               state_d = ST_RESULT;
            end
            ST_RESULT: begin
               result_out_d = bus.result_in;
               if (bus.result_in == SPEECH_C) begin
                  run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
               end else begin
                  run_cnt_d = 8'd0;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d    = ST_IDLE;
               dp_count_d = 6'd0;
            end
         endcase
      end
      vad_d  = (run_cnt_d >= HANG_C);
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dp_count_q   <= 6'd0;
         result_out_q <= 2'b00;
         run_cnt_q    <= 8'd0;
         vad_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         dp_count_q   <= dp_count_d;
         result_out_q <= result_out_d;
         run_cnt_q    <= run_cnt_d;
         vad_q        <= vad_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Directed scoreboard bench for bnn_seq_ctrl.
// It covers frame timing, stalls, hangover, abort, reset mid-frame and a start issued during compare.
module tb_bnn_seq_ctrl;
   localparam int NUM_POS     = 36;
   localparam int HANG_FRAMES = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   run_model;
   logic [1:0] sb_q[$];

   bnn_seq_if bus ();

   bnn_seq_ctrl #(.NUM_POS(NUM_POS), .HANG_FRAMES(HANG_FRAMES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic update_run(input logic [1:0] res);
      if (res == 2'b10) begin
         run_model = (run_model == 255) ? 255 : run_model + 1;
      end else begin
         run_model = 0;
      end
   endtask

   task automatic run_frame(input logic [1:0] res, input int stall_at, input int stall_len,
                            input bit start_in_cmp, input int exp_rv);
      int c, idx, stall_rem, cmp_c, rv_c;
      bit done;
      logic [1:0] exp_res;
      sb_q.push_back(res);
      bus.result_in  = res;
      bus.start      = 1'b1;
      bus.mfcc_valid = 1'b1;
      #1;
      chk("idle_ready", bus.mfcc_ready, 0);
      chk("idle_busy", bus.busy, 0);
      step();
      c = 1; idx = 0; stall_rem = stall_len; cmp_c = -1; rv_c = -1; done = 0;
      while (!done && c < 200) begin
         bus.start      = 1'b0;
         bus.mfcc_valid = !(idx == stall_at && stall_rem > 0);
         #1;
         if (bus.mfcc_ready) begin
            chk("dp_count", bus.dp_count, idx);
            chk("acc_en", bus.acc_en, bus.mfcc_valid);
            chk("acc_clr", bus.acc_clr, bus.mfcc_valid && idx == 0);
            if (bus.mfcc_valid) idx = (idx == NUM_POS - 1) ? 0 : idx + 1;
            else stall_rem--;
         end else begin
            chk("acc_en_off", bus.acc_en, 0);
            chk("acc_clr_off", bus.acc_clr, 0);
         end
         if (bus.cmp_en) begin
            cmp_c = c;
            chk("cmp_ready", bus.mfcc_ready, 0);
            if (start_in_cmp) bus.start = 1'b1;
         end
         if (bus.result_valid) begin
            rv_c = c;
            done = 1;
         end
         step();
         c++;
      end
      bus.start = 1'b0;
      chk("rv_seen", done, 1);
      chk("rv_cycle", rv_c, exp_rv);
      chk("cmp_cycle", cmp_c, exp_rv - 1);
      if (sb_q.size() > 0) begin
         exp_res = sb_q.pop_front();
         chk("result_out", bus.result_out, exp_res);
         update_run(exp_res);
      end else begin
         chk("sb_underflow", sb_q.size(), 1);
      end
      chk("vad", bus.vad_duration, run_model >= HANG_FRAMES);
      chk("rv_pulse", bus.result_valid, 0);
      chk("busy_done", bus.busy, 0);
   endtask

   initial begin
      int extra_rv;
      checks = 0; errors = 0; run_model = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.mfcc_valid = 1'b0; bus.result_in = 2'b00;
      #2;
      chk("rst_dp", bus.dp_count, 0);
      chk("rst_res", bus.result_out, 0);
      chk("rst_rv", bus.result_valid, 0);
      chk("rst_vad", bus.vad_duration, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.mfcc_ready, 0);
      #10 rst_n = 1'b1;
      step();

      // Three speech frames; the second has a 5-cycle stall at column 10.
      run_frame(2'b10, -1, 0, 0, NUM_POS + 2);
      run_frame(2'b10, 10, 5, 0, NUM_POS + 7);
      run_frame(2'b10, -1, 0, 0, NUM_POS + 2);

      // Abort together with the beat at column 20.
      bus.result_in = 2'b01; bus.start = 1'b1; bus.mfcc_valid = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 20; k++) step();
      bus.abort = 1'b1;
      #1;
      chk("abort_dp_before", bus.dp_count, 20);
      chk("abort_acc_en", bus.acc_en, 0);
      chk("abort_ready", bus.mfcc_ready, 0);
      step();
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_dp", bus.dp_count, 0);
      for (int k = 0; k < 5; k++) begin
         chk("abort_no_rv", bus.result_valid, 0);
         step();
      end
      chk("abort_res_hold", bus.result_out, 2'b10);
      chk("abort_vad_hold", bus.vad_duration, 1);

      // Noise frame after the abort: restarts at column 0 and drops the hangover.
      run_frame(2'b01, -1, 0, 0, NUM_POS + 2);

      // Start during COMPARE must be ignored.
      run_frame(2'b10, -1, 0, 1, NUM_POS + 2);
      extra_rv = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.result_valid) extra_rv++;
         chk("cmp_start_idle", bus.busy, 0);
         step();
      end
      chk("cmp_start_one_rv", extra_rv, 0);

      // Reset at column 15.
      bus.result_in = 2'b10; bus.start = 1'b1; bus.mfcc_valid = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 15; k++) step();
      chk("pre_rst_dp", bus.dp_count, 15);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dp", bus.dp_count, 0);
      chk("mid_rst_res", bus.result_out, 0);
      chk("mid_rst_rv", bus.result_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ready", bus.mfcc_ready, 0);
      run_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post_rst_wait", bus.busy, 0);
      end
      run_frame(2'b10, -1, 0, 0, NUM_POS + 2);
      chk("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
